// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: data width and the read-owner encoding used
// by the data-memory arbiter.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core load/store port and the debug read port.
// Define DMEM_ARB_STARVE_EN to add the debug anti-starvation wait counter.
module dmem_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned DBG_MAX_WAIT = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            core_req_i,
  input  logic            core_we_i,
  input  logic [XLEN-1:0] core_addr_i,
  input  logic [XLEN-1:0] core_wdata_i,
  output logic            core_gnt_o,
  output logic            core_rvalid_o,
  output logic [XLEN-1:0] core_rdata_o,
  input  logic            dbg_req_i,
  input  logic [XLEN-1:0] dbg_addr_i,
  output logic            dbg_gnt_o,
  output logic            dbg_rvalid_o,
  output logic [XLEN-1:0] dbg_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i
);

  // Handshake: a requester holds req and its address/data stable until the
  // cycle its gnt is high; that cycle is the access, reads answer one cycle later.

  if (DBG_MAX_WAIT < 1 || DBG_MAX_WAIT > 15) begin : g_bad_cfg
    $error("dmem_arbiter: DBG_MAX_WAIT must be in 1..15");
  end

  owner_e owner_q;
  logic   force_dbg;

`ifdef DMEM_ARB_STARVE_EN
  localparam logic [3:0] MAX_WAIT = 4'(DBG_MAX_WAIT);
  logic [3:0] wait_q;

  assign force_dbg = dbg_req_i && (wait_q == MAX_WAIT);

  // Counts core grants that overtook a pending debug read.
  always_ff @(posedge clk_i) begin
    if (rst_i || !dbg_req_i || dbg_gnt_o) begin
      wait_q <= 4'd0;
    end else if (core_gnt_o && wait_q != MAX_WAIT) begin
      wait_q <= wait_q + 4'd1;
    end
  end
`else
  assign force_dbg = 1'b0;
`endif

  always_comb begin
    core_gnt_o = 1'b0;
    dbg_gnt_o  = 1'b0;
    if (!rst_i) begin
      if (dbg_req_i && (force_dbg || !core_req_i)) begin
        dbg_gnt_o = 1'b1;
      end else if (core_req_i) begin
        core_gnt_o = 1'b1;
      end
    end
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (core_gnt_o) begin
      mem_req_o   = 1'b1;
      mem_we_o    = core_we_i;
      mem_addr_o  = core_addr_i;
      mem_wdata_o = core_wdata_i;
    end else if (dbg_gnt_o) begin
      mem_req_o  = 1'b1;
      mem_addr_o = dbg_addr_i;
    end
  end

  // Owner of the read whose data arrives next cycle; writes leave it NONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= OWN_NONE;
    end else if (core_gnt_o && !core_we_i) begin
      owner_q <= OWN_CORE;
    end else if (dbg_gnt_o) begin
      owner_q <= OWN_DBG;
    end else begin
      owner_q <= OWN_NONE;
    end
  end

  // Gating with rst_i drops a response that was in flight when reset rose.
  assign core_rvalid_o = !rst_i && (owner_q == OWN_CORE);
  assign dbg_rvalid_o  = !rst_i && (owner_q == OWN_DBG);
  assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
  assign dbg_rdata_o   = dbg_rvalid_o  ? mem_rdata_i : '0;

endmodule
